// File: rtl/prog_counter.sv
// rtl/prog_counter.sv - phased instruction address sequencer with return stack
module prog_counter #(
   parameter int AW     = 8,
   parameter int PHASES = 4,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      start,
   input  logic                      finish,
   input  logic                      load,
   input  logic                      inc,
   input  logic                      call,
   input  logic                      ret,
   input  logic [AW-1:0]             C_bus,
   output logic [AW-1:0]             ins_address,
   output logic [$clog2(PHASES)-1:0] phase,
   output logic                      commit,
   output logic                      running,
   output logic                      halted,
   output logic                      stack_err
);

   localparam int PW = $clog2(PHASES);
   localparam int SW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
   localparam logic [SW-1:0] FULL_SP    = SW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [AW-1:0]   addr_q,  addr_d;
   logic [SW-1:0]   sp_q,    sp_d;
   logic            err_q,   err_d;
   logic [AW-1:0]   stack_q [DEPTH];

   logic            commit_w;
   logic            act_w;
   logic            push_w;
   logic [AW-1:0]   addr_inc_w;
   logic [IW-1:0]   wr_idx_w;
   logic [IW-1:0]   rd_idx_w;

   // sequencer state register; reset returns to IDLE immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // state transitions; finish wins over start, HALT only leaves via reset
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (finish) begin
               state_d = ST_HALT;
            end else if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (finish) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // state-derived outputs; commit marks the last phase of an enabled instruction
   always_comb begin
      commit_w = (state_q == ST_RUN) && enable && (phase_q == LAST_PHASE);
      commit   = commit_w;
      running  = (state_q == ST_RUN);
      halted   = (state_q == ST_HALT);
   end

   // a commit is acted on only when no halt request arrives on the same edge
   assign act_w      = commit_w && !finish;
   assign addr_inc_w = addr_q + AW'(1);
   assign wr_idx_w   = IW'(sp_q);
   assign rd_idx_w   = IW'(sp_q - SW'(1));

   // phase advances only while running and enabled; a halt freezes it
   always_comb begin
      phase_d = phase_q;
      if ((state_q == ST_RUN) && enable && !finish) begin
         if (phase_q == LAST_PHASE) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + PW'(1);
         end
      end
   end

   // commit action selection: ret > call > load > inc > hold
   always_comb begin
      addr_d = addr_q;
      sp_d   = sp_q;
      err_d  = err_q;
      push_w = 1'b0;
      if (act_w) begin
         if (ret) begin
            if (sp_q != '0) begin
               addr_d = stack_q[rd_idx_w];
               sp_d   = sp_q - SW'(1);
            end else begin
               err_d = 1'b1;
            end
         end else if (call) begin
            if (sp_q != FULL_SP) begin
               push_w = 1'b1;
               addr_d = C_bus;
               sp_d   = sp_q + SW'(1);
            end else begin
               err_d = 1'b1;
            end
         end else if (load) begin
            addr_d = C_bus;
         end else if (inc) begin
            addr_d = addr_inc_w;
         end
      end
   end

   // datapath registers: phase, address, stack pointer and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= '0;
         addr_q  <= '0;
         sp_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         addr_q  <= addr_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
      end
   end

   // return-stack storage; entries above the pointer are never read, so no reset
   always_ff @(posedge clk) begin
      if (push_w) begin
         stack_q[wr_idx_w] <= addr_inc_w;
      end
   end

   assign ins_address = addr_q;
   assign phase       = phase_q;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_prog_counter.sv
// tb/tb_prog_counter.sv - directed self-checking bench for prog_counter
module tb_prog_counter;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       start;
   logic       finish;
   logic       load;
   logic       inc;
   logic       call;
   logic       ret;
   logic [7:0] C_bus;
   logic [7:0] ins_address;
   logic [1:0] phase;
   logic       commit;
   logic       running;
   logic       halted;
   logic       stack_err;

   int n_pass;
   int n_total;

   prog_counter #(.AW(8), .PHASES(4), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start      (start),
      .finish     (finish),
      .load       (load),
      .inc        (inc),
      .call       (call),
      .ret        (ret),
      .C_bus      (C_bus),
      .ins_address(ins_address),
      .phase      (phase),
      .commit     (commit),
      .running    (running),
      .halted     (halted),
      .stack_err  (stack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      enable = 1'b1;
      start  = 1'b0;
      finish = 1'b0;
      load   = 1'b0;
      inc    = 1'b0;
      call   = 1'b0;
      ret    = 1'b0;
      C_bus  = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic go_commit(input string tag);
      int k;
      k = 0;
      while (commit !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      if (commit !== 1'b1) begin
         n_total++;
         $display("FAIL %s commit_timeout: got %b, expected 1", tag, commit);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_ctl();
      #1;
      n_total++; if (ins_address !== 8'h00) $display("FAIL rst_addr: got %0h, expected 0", ins_address); else n_pass++;
      n_total++; if (phase !== 2'd0) $display("FAIL rst_phase: got %0d, expected 0", phase); else n_pass++;
      n_total++; if ({commit, running, halted, stack_err} !== 4'b0000)
         $display("FAIL rst_flags: got %b, expected 0000", {commit, running, halted, stack_err}); else n_pass++;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_start_inc();
      int ncommit;
      tick();
      n_total++; if (running !== 1'b0) $display("FAIL idle_no_start: got %b, expected 0", running); else n_pass++;
      start_run();
      n_total++; if ({running, halted} !== 2'b10) $display("FAIL start_state: got %b, expected 10", {running, halted}); else n_pass++;
      n_total++; if (phase !== 2'd0) $display("FAIL start_phase: got %0d, expected 0", phase); else n_pass++;
      inc = 1'b1;
      ncommit = 0;
      for (int k = 1; k <= 16; k++) begin
         if (commit === 1'b1) ncommit++;
         tick();
         if (k % 4 == 0) begin
            n_total++;
            if (ins_address !== 8'(k / 4)) $display("FAIL inc_seq_%0d: got %0h, expected %0h", k, ins_address, k / 4);
            else n_pass++;
         end
      end
      inc = 1'b0;
      n_total++; if (ncommit != 4) $display("FAIL commit_count: got %0d, expected 4", ncommit); else n_pass++;
   endtask

   task automatic test_wrap();
      go_commit("wrap_load");
      load = 1'b1; C_bus = 8'hFF;
      tick();
      load = 1'b0;
      n_total++; if (ins_address !== 8'hFF) $display("FAIL wrap_load: got %0h, expected ff", ins_address); else n_pass++;
      go_commit("wrap_inc");
      inc = 1'b1;
      tick();
      inc = 1'b0;
      n_total++; if (ins_address !== 8'h00) $display("FAIL wrap_inc: got %0h, expected 0", ins_address); else n_pass++;
      n_total++; if (stack_err !== 1'b0) $display("FAIL wrap_err: got %b, expected 0", stack_err); else n_pass++;
   endtask

   task automatic test_call_ret();
      go_commit("cr_load");
      load = 1'b1; C_bus = 8'h10;
      tick();
      load = 1'b0;
      go_commit("cr_call");
      call = 1'b1; C_bus = 8'h40;
      tick();
      call = 1'b0;
      n_total++; if (ins_address !== 8'h40) $display("FAIL call_target: got %0h, expected 40", ins_address); else n_pass++;
      go_commit("cr_ret");
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_total++; if (ins_address !== 8'h11) $display("FAIL ret_addr: got %0h, expected 11", ins_address); else n_pass++;
      n_total++; if (stack_err !== 1'b0) $display("FAIL ret_err: got %b, expected 0", stack_err); else n_pass++;
      go_commit("cr_ret_empty");
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_total++; if (ins_address !== 8'h11) $display("FAIL ret_empty_addr: got %0h, expected 11", ins_address); else n_pass++;
      n_total++; if (stack_err !== 1'b1) $display("FAIL ret_empty_err: got %b, expected 1", stack_err); else n_pass++;
      go_commit("cr_sticky");
      inc = 1'b1;
      tick();
      inc = 1'b0;
      n_total++; if ({ins_address, stack_err} !== {8'h12, 1'b1})
         $display("FAIL err_sticky: got %0h/%b, expected 12/1", ins_address, stack_err); else n_pass++;
   endtask

   task automatic test_nested();
      logic [7:0] tgt [5];
      logic [7:0] exp_a [5];
      tgt   = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      exp_a = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h50};
      do_reset();
      start_run();
      for (int i = 0; i < 5; i++) begin
         go_commit("nest_call");
         call = 1'b1; C_bus = tgt[i];
         tick();
         call = 1'b0;
         n_total++;
         if ({ins_address, stack_err} !== {exp_a[i], (i == 4)})
            $display("FAIL nest_call_%0d: got %0h/%b, expected %0h/%b", i, ins_address, stack_err, exp_a[i], (i == 4));
         else n_pass++;
      end
      go_commit("nest_ret1");
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_total++; if (ins_address !== 8'h41) $display("FAIL nest_ret1: got %0h, expected 41", ins_address); else n_pass++;
      go_commit("nest_ret2");
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_total++; if (ins_address !== 8'h31) $display("FAIL nest_ret2: got %0h, expected 31", ins_address); else n_pass++;
      go_commit("nest_prio");
      ret = 1'b1; call = 1'b1; load = 1'b1; inc = 1'b1; C_bus = 8'h77;
      tick();
      clear_ctl();
      n_total++; if (ins_address !== 8'h21) $display("FAIL ret_priority: got %0h, expected 21", ins_address); else n_pass++;
      go_commit("nest_ret4");
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_total++; if (ins_address !== 8'h01) $display("FAIL nest_ret4: got %0h, expected 1", ins_address); else n_pass++;
      do_reset();
      n_total++; if (stack_err !== 1'b0) $display("FAIL err_cleared: got %b, expected 0", stack_err); else n_pass++;
      start_run();
      go_commit("underflow");
      ret = 1'b1;
      tick();
      ret = 1'b0;
      n_total++; if ({ins_address, stack_err} !== {8'h00, 1'b1})
         $display("FAIL underflow: got %0h/%b, expected 0/1", ins_address, stack_err); else n_pass++;
   endtask

   task automatic test_finish();
      do_reset();
      start_run();
      go_commit("fin_inc");
      inc = 1'b1;
      tick();
      inc = 1'b0;
      go_commit("fin_load");
      load = 1'b1; finish = 1'b1; C_bus = 8'h55;
      tick();
      clear_ctl();
      n_total++; if ({halted, running, commit} !== 3'b100)
         $display("FAIL fin_state: got %b, expected 100", {halted, running, commit}); else n_pass++;
      n_total++; if ({ins_address, phase} !== {8'h01, 2'd3})
         $display("FAIL fin_frozen: got %0h/%0d, expected 1/3", ins_address, phase); else n_pass++;
      start = 1'b1; inc = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      clear_ctl();
      n_total++; if ({halted, running, commit, ins_address, phase} !== {3'b100, 8'h01, 2'd3})
         $display("FAIL halt_hold: got %b/%0h/%0d, expected 100/1/3", {halted, running, commit}, ins_address, phase);
      else n_pass++;
      do_reset();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      n_total++; if ({halted, running} !== 2'b10) $display("FAIL idle_finish: got %b, expected 10", {halted, running}); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      start_run();
      inc = 1'b1;
      go_commit("ar_inc");
      tick();
      tick();
      tick();
      n_total++; if ({ins_address, phase} !== {8'h01, 2'd2})
         $display("FAIL ar_pre: got %0h/%0d, expected 1/2", ins_address, phase); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_total++; if ({ins_address, phase, commit, running, halted, stack_err} !== 14'd0)
         $display("FAIL ar_zero: got %0h/%0d/%b, expected 0/0/0000", ins_address, phase, {commit, running, halted, stack_err});
      else n_pass++;
      #1;
      reset = 1'b0;
      tick();
      tick();
      inc = 1'b0;
      n_total++; if ({running, ins_address} !== {1'b0, 8'h00})
         $display("FAIL ar_no_resume: got %b/%0h, expected 0/0", running, ins_address); else n_pass++;
   endtask

   task automatic test_enable();
      start_run();
      inc = 1'b1;
      tick();
      tick();
      enable = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      n_total++; if ({ins_address, phase} !== {8'h00, 2'd2})
         $display("FAIL en_freeze: got %0h/%0d, expected 0/2", ins_address, phase); else n_pass++;
      enable = 1'b1;
      tick();
      n_total++; if (commit !== 1'b1) $display("FAIL en_commit_hi: got %b, expected 1", commit); else n_pass++;
      enable = 1'b0;
      #1;
      n_total++; if (commit !== 1'b0) $display("FAIL en_commit_lo: got %b, expected 0", commit); else n_pass++;
      tick();
      n_total++; if ({ins_address, phase} !== {8'h00, 2'd3})
         $display("FAIL en_hold_commit: got %0h/%0d, expected 0/3", ins_address, phase); else n_pass++;
      enable = 1'b1;
      tick();
      inc = 1'b0;
      n_total++; if ({ins_address, phase} !== {8'h01, 2'd0})
         $display("FAIL en_resume: got %0h/%0d, expected 1/0", ins_address, phase); else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_start_inc();
      test_wrap();
      test_call_ret();
      test_nested();
      test_finish();
      test_async_reset();
      test_enable();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
